fft_agu: RTL and testbench

- Address-generation and sequencing controller for the 512-point radix-2 in-place FFT.
- Drives read and write addresses for the ping-pong sample RAM banks (9-bit addresses, one-cycle synchronous read) and the 9-bit address of the 256-entry synchronous twiddle ROM.
- Sits directly upstream of the RAM/ROM stage: this block emits the addresses and the RAMs/ROM return data one cycle later.
- The delayed write side matches the read-plus-butterfly pipeline.

---
 rtl/fft_agu.sv | 166 ++++++++++++++++
 tb/tb_fft_agu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_agu.sv
// fft_agu: read/write address generator and sequencer for a 512-point radix-2 in-place FFT.
// Defining FFT_AGU_STALL_EN adds a stall input that freezes the whole block while high.
module fft_agu #(
  parameter int N_LEVELS = 9,
  parameter int LATENCY  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef FFT_AGU_STALL_EN
  input  logic       stall,
`endif
  output logic [8:0] rd_adr_a,
  output logic [8:0] rd_adr_b,
  output logic [8:0] twiddle_address,
  output logic       rd_bank,
  output logic [8:0] wr_adr_a,
  output logic [8:0] wr_adr_b,
  output logic       wr_bank,
  output logic       we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] tw;
    logic       bank;
  } rd_t;

  localparam logic [2:0] FLUSH_LAST = 3'(LATENCY - 1);
  localparam logic [3:0] LAST_LEVEL = 4'(N_LEVELS - 1);

  state_t     state;
  logic [3:0] level;
  logic [7:0] bfly;
  logic [2:0] flush_cnt;
  logic       advance;
  logic       issue;

  logic [LATENCY-1:0] pipe_valid;
  logic [8:0]         pipe_a    [LATENCY];
  logic [8:0]         pipe_b    [LATENCY];
  logic               pipe_bank [LATENCY];

  function automatic logic [8:0] rotl9(input logic [8:0] x, input logic [3:0] s);
    logic [17:0] d;
    d = {x, x} << s;
    return d[17:9];
  endfunction

  // Butterfly i at a level: operands are {i,0}/{i,1} rotated left by the level; the
  // twiddle keeps only the top `level` bits of i, so level 0 always uses W^0.
  function automatic rd_t rd_for(input logic [7:0] idx, input logic [3:0] lvl);
    rd_t        r;
    logic [7:0] mask;
    mask   = 8'hFF << (4'd8 - lvl);
    r.a    = rotl9({idx, 1'b0}, lvl);
    r.b    = rotl9({idx, 1'b1}, lvl);
    r.tw   = {1'b0, idx & mask};
    r.bank = lvl[0];
    return r;
  endfunction

`ifdef FFT_AGU_STALL_EN
  assign advance = ~stall;
  assign we      = pipe_valid[LATENCY-1] & ~stall;
`else
  assign advance = 1'b1;
  assign we      = pipe_valid[LATENCY-1];
`endif

  // The read registers always show the butterfly being issued while state is RUN.
  assign issue    = (state == RUN);
  assign wr_adr_a = pipe_a[LATENCY-1];
  assign wr_adr_b = pipe_b[LATENCY-1];
  assign wr_bank  = pipe_bank[LATENCY-1];

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      level     <= '0;
      bfly      <= '0;
      flush_cnt <= '0;
      {rd_adr_a, rd_adr_b, twiddle_address, rd_bank} <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (advance) begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            level <= '0;
            bfly  <= '0;
            busy  <= 1'b1;
            {rd_adr_a, rd_adr_b, twiddle_address, rd_bank} <= rd_for(8'd0, 4'd0);
          end
        end
        RUN: begin
          if (bfly == 8'hFF) begin
            state     <= FLUSH;
            bfly      <= '0;
            flush_cnt <= '0;
          end else begin
            bfly <= bfly + 8'd1;
            {rd_adr_a, rd_adr_b, twiddle_address, rd_bank} <= rd_for(bfly + 8'd1, level);
          end
        end
        FLUSH: begin
          // Drain the write pipe before the next level reads what this one wrote.
          if (flush_cnt == FLUSH_LAST) begin
            if (level < LAST_LEVEL) begin
              state <= RUN;
              level <= level + 4'd1;
              {rd_adr_a, rd_adr_b, twiddle_address, rd_bank} <= rd_for(8'd0, level + 4'd1);
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            flush_cnt <= flush_cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the pipe is a few flops, not a RAM, so it is reset with everything else;
  // that is what makes we drop the moment reset asserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int j = 0; j < LATENCY; j++) begin
        pipe_a[j]    <= '0;
        pipe_b[j]    <= '0;
        pipe_bank[j] <= 1'b0;
      end
    end else if (advance) begin
      pipe_valid[0] <= issue;
      // Idle slots repeat the last issued entry so the write outputs hold their value.
      if (issue) begin
        pipe_a[0]    <= rd_adr_a;
        pipe_b[0]    <= rd_adr_b;
        pipe_bank[0] <= ~rd_bank;
      end
      for (int j = 1; j < LATENCY; j++) begin
        pipe_valid[j] <= pipe_valid[j-1];
        pipe_a[j]     <= pipe_a[j-1];
        pipe_b[j]     <= pipe_b[j-1];
        pipe_bank[j]  <= pipe_bank[j-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_agu.sv
// Self-checking bench for fft_agu: random start/stall traffic against a cycle-indexed
// arithmetic model of the transform schedule, plus per-level address coverage.
module tb_fft_agu;

  localparam int LAT    = 2;
  localparam int P      = 256 + LAT;
  localparam int END_T  = 9 * P;
  localparam int DONE_T = END_T + 1;
  localparam int BUDGET = 6000;

  typedef struct packed {
    logic [8:0] rd_a;
    logic [8:0] rd_b;
    logic [8:0] tw;
    logic       rd_bank;
    logic [8:0] wr_a;
    logic [8:0] wr_b;
    logic       wr_bank;
    logic       we;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall_now = 1'b0;
  logic [8:0] rd_adr_a, rd_adr_b, twiddle_address, wr_adr_a, wr_adr_b;
  logic       rd_bank, wr_bank, we, busy, done;

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t prior;
  int   cov [9][512];

  fft_agu #(.N_LEVELS(9), .LATENCY(LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
`ifdef FFT_AGU_STALL_EN
    .stall           (stall_now),
`endif
    .rd_adr_a        (rd_adr_a),
    .rd_adr_b        (rd_adr_b),
    .twiddle_address (twiddle_address),
    .rd_bank         (rd_bank),
    .wr_adr_a        (wr_adr_a),
    .wr_adr_b        (wr_adr_b),
    .wr_bank         (wr_bank),
    .we              (we),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t s;
    s.rd_a    = rd_adr_a;
    s.rd_b    = rd_adr_b;
    s.tw      = twiddle_address;
    s.rd_bank = rd_bank;
    s.wr_a    = wr_adr_a;
    s.wr_b    = wr_adr_b;
    s.wr_bank = wr_bank;
    s.we      = we;
    s.busy    = busy;
    s.done    = done;
    return s;
  endfunction

  function automatic int rotl(input int x, input int s);
    return ((x << s) | (x >> (9 - s))) & 511;
  endfunction

  // Active cycle u (1 = first cycle after start is accepted) issues a read iff it lies
  // in the first 256 cycles of one of the nine (256 + LAT)-cycle level slots.
  function automatic bit read_cycle(input int u);
    return (u >= 1) && (u <= END_T) && (((u - 1) % P) < 256);
  endfunction

  function automatic void last_read(input int u, output int lvl, output int i);
    if (u > END_T) begin
      lvl = 8;
      i   = 255;
    end else begin
      lvl = (u - 1) / P;
      i   = (u - 1) % P;
      if (i > 255) i = 255;
    end
  endfunction

  function automatic obs_t expected(input int t);
    obs_t e;
    int   lvl, i;
    e = '0;
    last_read(t, lvl, i);
    e.rd_a    = 9'(rotl(2 * i, lvl));
    e.rd_b    = 9'(rotl(2 * i + 1, lvl));
    e.tw      = 9'(i & ((255 << (8 - lvl)) & 255));
    e.rd_bank = 1'(lvl & 1);
    if (t - LAT >= 1) begin
      last_read(t - LAT, lvl, i);
      e.wr_a    = 9'(rotl(2 * i, lvl));
      e.wr_b    = 9'(rotl(2 * i + 1, lvl));
      e.wr_bank = 1'((lvl & 1) ^ 1);
      e.we      = read_cycle(t - LAT);
    end else begin
      e.wr_a    = prior.wr_a;
      e.wr_b    = prior.wr_b;
      e.wr_bank = prior.wr_bank;
    end
    e.busy = (t <= END_T);
    e.done = (t == DONE_T);
    return e;
  endfunction

  // One transform; reset_at > 0 aborts it with reset at that active cycle.
  task automatic run_transform(input int reset_at);
    int   t, prev_t, cyc, stalls, we_cnt, done_pulses, done_at, lvl, full;
    bit   prev_done;
    obs_t o, e;
    for (int l = 0; l < 9; l++)
      for (int a = 0; a < 512; a++) cov[l][a] = 0;
    repeat ($urandom_range(1, 8)) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 1; prev_t = 0; cyc = 1; stalls = 0; we_cnt = 0;
    done_pulses = 0; done_at = -1; prev_done = 1'b0;
    o = '0;
    while (t <= DONE_T + 3 && cyc < BUDGET) begin
      o = observe();
      e = expected(t);
      if (stall_now) e.we = 1'b0;
      check("cycle", o, e);
      if (t != prev_t) begin
        if (t == 1) begin
          check("l0_first_rd_a", o.rd_a, 0);
          check("l0_first_rd_b", o.rd_b, 1);
          check("l0_first_tw", o.tw, 0);
        end
        if (t == 6) begin
          check("l0_i5_rd_a", o.rd_a, 10);
          check("l0_i5_rd_b", o.rd_b, 11);
        end
        if (t == 1 + LAT) begin
          check("first_we", o.we, 1);
          check("first_wr_a", o.wr_a, 0);
          check("first_wr_bank", o.wr_bank, 1);
        end
        if (t == 8 * P + 4) begin
          check("l8_i3_rd_a", o.rd_a, 3);
          check("l8_i3_rd_b", o.rd_b, 259);
          check("l8_i3_tw", o.tw, 3);
          check("l8_rd_bank", o.rd_bank, 0);
        end
      end
      if (o.we && (t - LAT >= 1) && (t - LAT <= END_T)) begin
        lvl = (t - LAT - 1) / P;
        cov[lvl][o.wr_a]++;
        cov[lvl][o.wr_b]++;
        we_cnt++;
      end
      if (o.done && !prev_done) begin
        done_pulses++;
        done_at = cyc - stalls;
      end
      prev_done = o.done;
      prev_t    = t;
      if (t == reset_at) begin
        stall_now = 1'b0;
        reset     = 1'b1;
        #1;
        check("reset_async", observe(), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        prior = '0;
        return;
      end
      start = (t <= DONE_T) && (t == 100 || t == DONE_T || $urandom_range(0, 39) == 0);
`ifdef FFT_AGU_STALL_EN
      stall_now = ($urandom_range(0, 9) == 0);
`endif
      @(posedge clk);
      cyc++;
      if (stall_now) stalls++;
      else t++;
      #1;
    end
    start     = 1'b0;
    stall_now = 1'b0;
    check("timeout", t > DONE_T + 3, 1);
    check("we_count", we_cnt, 9 * 256);
    check("done_pulses", done_pulses, 1);
    check("done_latency", done_at, 9 * (256 + LAT) + 1);
    check("final_wr_bank", o.wr_bank, 1);
    for (int l = 0; l < 9; l++) begin
      full = 0;
      for (int a = 0; a < 512; a++) if (cov[l][a] == 1) full++;
      check("level_cover", full, 512);
    end
    prior = expected(DONE_T + 10);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", observe(), 0);
    reset = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      check("idle", observe(), 0);
    end
    prior = '0;
    run_transform(0);
    run_transform(700);
    run_transform(0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
